// File: rtl/model_standard_linear_pkg.sv
// Shared definitions for the standard linear state-space engine:
// controller state encoding, default word geometry and saturation bounds.
package model_standard_linear_pkg;

    localparam int DEFAULT_DATA_SIZE     = 64;
    localparam int DEFAULT_FRACTION_SIZE = 32;

    // Widest accumulator the bound helpers can describe (2 x 64-bit words).
    localparam int MAX_ACC_WIDTH = 128;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD_X,
        S_LOAD_U,
        S_ROW_A,
        S_ROW_B,
        S_WRITE,
        S_SWAP,
        S_DONE
    } state_t;

    // Largest signed value of a width-bit word, zero-extended to the accumulator width.
    function automatic logic [MAX_ACC_WIDTH-1:0] sat_max(input int width);
        logic [MAX_ACC_WIDTH-1:0] v;
        v = '0;
        for (int b = 0; b < width - 1; b++) v[b] = 1'b1;
        return v;
    endfunction

    // Smallest signed value of a width-bit word, sign-extended to the accumulator width.
    function automatic logic [MAX_ACC_WIDTH-1:0] sat_min(input int width);
        logic [MAX_ACC_WIDTH-1:0] v;
        v = '1;
        for (int b = 0; b < width - 1; b++) v[b] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/model_standard_linear_mac.sv
// Fixed-point multiply-accumulate for one state row: full-width product,
// arithmetic shift by the fraction width, double-width accumulation and
// narrowing of the next accumulator value to one data word.
// Build option STANDARD_LINEAR_SATURATION_EN: narrowing clamps to the signed
// word range instead of wrapping to the low DATA_SIZE bits.
module model_standard_linear_mac
    import model_standard_linear_pkg::*;
#(
    parameter int DATA_SIZE     = DEFAULT_DATA_SIZE,
    parameter int FRACTION_SIZE = DEFAULT_FRACTION_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [DATA_SIZE-1:0] coef,
    input  logic [DATA_SIZE-1:0] operand,
    output logic [DATA_SIZE-1:0] result_next
);

    localparam int ACC_W = 2 * DATA_SIZE;

    logic signed [ACC_W-1:0] coef_wide;
    logic signed [ACC_W-1:0] operand_wide;
    logic signed [ACC_W-1:0] product;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;

    assign coef_wide    = {{DATA_SIZE{coef[DATA_SIZE-1]}}, coef};
    assign operand_wide = {{DATA_SIZE{operand[DATA_SIZE-1]}}, operand};
    assign product      = coef_wide * operand_wide;
    assign term         = product >>> FRACTION_SIZE;
    assign acc_next     = enable ? acc + term : acc;

    // Accumulator: cleared between rows, advanced on every accepted coefficient.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst)       acc <= '0;
        else if (clear) acc <= '0;
        else            acc <= acc_next;
    end

`ifdef STANDARD_LINEAR_SATURATION_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(DATA_SIZE));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(DATA_SIZE));
`endif

    // Narrow the running sum to one word (clamped when saturation is built in).
    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned (no latch).
        result_next = acc_next[DATA_SIZE-1:0];
`ifdef STANDARD_LINEAR_SATURATION_EN
        if (acc_next > SAT_MAX)      result_next = SAT_MAX[DATA_SIZE-1:0];
        else if (acc_next < SAT_MIN) result_next = SAT_MIN[DATA_SIZE-1:0];
`endif
    end

endmodule

// File: rtl/model_standard_linear_engine.sv
// Iterative state-space engine: x(k+1)[i] = sum_j A[i][j]*x(k)[j] + sum_p B[i][p]*u(k)[p]
// for SIZE_K steps. State lives in a ping-pong buffer pair; coefficients are
// streamed once per use. One multiply-accumulate per cycle.
// Build option STANDARD_LINEAR_SATURATION_EN selects clamping instead of wrapping
// when a row result is narrowed (see model_standard_linear_mac).
module model_standard_linear_engine
    import model_standard_linear_pkg::*;
#(
    parameter int DATA_SIZE     = DEFAULT_DATA_SIZE,
    parameter int FRACTION_SIZE = DEFAULT_FRACTION_SIZE,
    parameter int X_MAX         = 64,   // at least 2
    parameter int U_MAX         = 64    // at least 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 BUSY,
    output logic                 ERROR,
    input  logic [DATA_SIZE-1:0] SIZE_X_IN,
    input  logic [DATA_SIZE-1:0] SIZE_U_IN,
    input  logic [DATA_SIZE-1:0] SIZE_K_IN,
    input  logic [DATA_SIZE-1:0] X_IN,
    input  logic                 X_IN_VALID,
    output logic                 X_IN_READY,
    input  logic [DATA_SIZE-1:0] U_IN,
    input  logic                 U_IN_VALID,
    output logic                 U_IN_READY,
    input  logic [DATA_SIZE-1:0] COEF_IN,
    input  logic                 COEF_IN_VALID,
    output logic                 COEF_IN_READY,
    output logic [DATA_SIZE-1:0] X_OUT,
    output logic                 X_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] X_OUT_I,
    output logic [DATA_SIZE-1:0] X_OUT_K
);

    localparam int XW = $clog2(X_MAX);
    localparam int UW = $clog2(U_MAX);
    localparam int CW = $clog2(((X_MAX > U_MAX) ? X_MAX : U_MAX) + 1);

    localparam logic [CW-1:0]               CNT_ONE = CW'(1);
    localparam logic [DATA_SIZE-1:0]        ONE     = DATA_SIZE'(1);
    localparam logic signed [DATA_SIZE-1:0] S_ZERO  = '0;
    localparam logic signed [DATA_SIZE-1:0] S_ONE   = DATA_SIZE'(1);
    localparam logic signed [DATA_SIZE-1:0] S_X_MAX = DATA_SIZE'(X_MAX);
    localparam logic signed [DATA_SIZE-1:0] S_U_MAX = DATA_SIZE'(U_MAX);

    state_t               state;
    logic                 sel;        // buffer holding x(k); ~sel receives x(k+1)
    logic [DATA_SIZE-1:0] size_x, size_u, size_k;
    logic [DATA_SIZE-1:0] k_cnt;
    logic [CW-1:0]        cnt;        // element index within the current load or row pass
    logic [CW-1:0]        row;

    logic [DATA_SIZE-1:0] x_buf [2][X_MAX];
    logic [DATA_SIZE-1:0] u_buf [U_MAX];

    logic                 x_take, u_take, coef_take;
    logic                 last_x, last_u, last_row, u_none, sizes_ok, row_done;
    logic [DATA_SIZE-1:0] k_next;
    logic [DATA_SIZE-1:0] operand;
    logic [DATA_SIZE-1:0] mac_result;
    logic                 mac_clear;

    assign X_IN_READY    = (state == S_LOAD_X);
    assign U_IN_READY    = (state == S_LOAD_U);
    assign COEF_IN_READY = (state == S_ROW_A) || (state == S_ROW_B);

    assign x_take    = X_IN_VALID    && X_IN_READY;
    assign u_take    = U_IN_VALID    && U_IN_READY;
    assign coef_take = COEF_IN_VALID && COEF_IN_READY;

    assign u_none   = (size_u == '0);
    assign last_x   = (DATA_SIZE'(cnt) == size_x - ONE);
    assign last_u   = (DATA_SIZE'(cnt) == size_u - ONE);
    assign last_row = (DATA_SIZE'(row) == size_x - ONE);
    assign k_next   = k_cnt + ONE;

    assign sizes_ok = ($signed(size_x) >= S_ONE)  && ($signed(size_x) <= S_X_MAX) &&
                      ($signed(size_u) >= S_ZERO) && ($signed(size_u) <= S_U_MAX) &&
                      ($signed(size_k) >= S_ONE);

    // Last coefficient of the row is being accepted: the row result is final.
    assign row_done = coef_take && (((state == S_ROW_A) && last_x && u_none) ||
                                    ((state == S_ROW_B) && last_u));

    assign operand   = (state == S_ROW_A) ? x_buf[sel][cnt[XW-1:0]] : u_buf[cnt[UW-1:0]];
    assign mac_clear = !COEF_IN_READY;

    model_standard_linear_mac #(
        .DATA_SIZE     (DATA_SIZE),
        .FRACTION_SIZE (FRACTION_SIZE)
    ) u_mac (
        .clk         (CLK),
        .rst         (RST),
        .clear       (mac_clear),
        .enable      (coef_take),
        .coef        (COEF_IN),
        .operand     (operand),
        .result_next (mac_result)
    );

    // Buffer writes: initial state, per-step input vector and finished rows into the shadow side.
    always_ff @(posedge CLK) begin
        // NOTE: storage arrays carry no reset; every element is written before it is read.
        if (x_take)             x_buf[sel][cnt[XW-1:0]]   <= X_IN;
        if (u_take)             u_buf[cnt[UW-1:0]]        <= U_IN;
        if (state == S_WRITE)   x_buf[~sel][row[XW-1:0]]  <= X_OUT;
    end

    // Sequencer: size check, loads, row passes, buffer swap and completion, with registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= S_IDLE;
            sel          <= 1'b0;
            size_x       <= '0;
            size_u       <= '0;
            size_k       <= '0;
            k_cnt        <= '0;
            cnt          <= '0;
            row          <= '0;
            READY        <= 1'b0;
            BUSY         <= 1'b0;
            ERROR        <= 1'b0;
            X_OUT        <= '0;
            X_OUT_ENABLE <= 1'b0;
            X_OUT_I      <= '0;
            X_OUT_K      <= '0;
        end else begin
            READY        <= 1'b0;
            X_OUT_ENABLE <= 1'b0;

            if (row_done) begin
                X_OUT        <= mac_result;
                X_OUT_ENABLE <= 1'b1;
                X_OUT_I      <= DATA_SIZE'(row);
                X_OUT_K      <= k_cnt;
            end

            case (state)
                S_IDLE: begin
                    if (START) begin
                        size_x <= SIZE_X_IN;
                        size_u <= SIZE_U_IN;
                        size_k <= SIZE_K_IN;
                        BUSY   <= 1'b1;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    cnt   <= '0;
                    row   <= '0;
                    k_cnt <= '0;
                    if (sizes_ok) begin
                        ERROR <= 1'b0;
                        state <= S_LOAD_X;
                    end else begin
                        ERROR <= 1'b1;
                        READY <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_LOAD_X: begin
                    if (x_take) begin
                        if (last_x) begin
                            cnt   <= '0;
                            state <= u_none ? S_ROW_A : S_LOAD_U;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_LOAD_U: begin
                    if (u_take) begin
                        if (last_u) begin
                            cnt   <= '0;
                            state <= S_ROW_A;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_ROW_A: begin
                    if (coef_take) begin
                        if (last_x) begin
                            cnt   <= '0;
                            state <= u_none ? S_WRITE : S_ROW_B;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_ROW_B: begin
                    if (coef_take) begin
                        if (last_u) begin
                            cnt   <= '0;
                            state <= S_WRITE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_WRITE: begin
                    if (last_row) begin
                        state <= S_SWAP;
                    end else begin
                        row   <= row + CNT_ONE;
                        state <= S_ROW_A;
                    end
                end
                S_SWAP: begin
                    sel   <= ~sel;
                    k_cnt <= k_next;
                    row   <= '0;
                    if (k_next < size_k) begin
                        state <= u_none ? S_ROW_A : S_LOAD_U;
                    end else begin
                        READY <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_model_standard_linear_engine.sv
// Directed bench for model_standard_linear_engine at DATA_SIZE=16, FRACTION_SIZE=8
// (1.0 = 0x0100), X_MAX=U_MAX=4. Expected values are hand-computed constants.
module tb_model_standard_linear_engine;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int XM = 4;
    localparam int UM = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          START = 1'b0;
    logic          READY, BUSY, ERROR;
    logic [DW-1:0] SIZE_X_IN = '0, SIZE_U_IN = '0, SIZE_K_IN = '0;
    logic [DW-1:0] X_IN = '0, U_IN = '0, COEF_IN = '0;
    logic          X_IN_VALID = 1'b0, U_IN_VALID = 1'b0, COEF_IN_VALID = 1'b0;
    logic          X_IN_READY, U_IN_READY, COEF_IN_READY;
    logic [DW-1:0] X_OUT, X_OUT_I, X_OUT_K;
    logic          X_OUT_ENABLE;

    int checks = 0;
    int errors = 0;

    // Stimulus tables and captured results.
    logic [DW-1:0] x_data [16];
    logic [DW-1:0] u_data [16];
    logic [DW-1:0] c_data [16];
    int            nx, nu, nc;
    logic [DW-1:0] o_val [16];
    int            o_i [16];
    int            o_k [16];
    int            o_cyc [16];
    int            n_out, ready_cyc, coefs_taken;
    bit            got_ready, got_err, aborted, ever_x, ever_u, ever_c;

    always #5 CLK = ~CLK;

    model_standard_linear_engine #(
        .DATA_SIZE (DW), .FRACTION_SIZE (FW), .X_MAX (XM), .U_MAX (UM)
    ) dut (
        .CLK (CLK), .RST (RST), .START (START),
        .READY (READY), .BUSY (BUSY), .ERROR (ERROR),
        .SIZE_X_IN (SIZE_X_IN), .SIZE_U_IN (SIZE_U_IN), .SIZE_K_IN (SIZE_K_IN),
        .X_IN (X_IN), .X_IN_VALID (X_IN_VALID), .X_IN_READY (X_IN_READY),
        .U_IN (U_IN), .U_IN_VALID (U_IN_VALID), .U_IN_READY (U_IN_READY),
        .COEF_IN (COEF_IN), .COEF_IN_VALID (COEF_IN_VALID), .COEF_IN_READY (COEF_IN_READY),
        .X_OUT (X_OUT), .X_OUT_ENABLE (X_OUT_ENABLE), .X_OUT_I (X_OUT_I), .X_OUT_K (X_OUT_K)
    );

    // Runs one operation from a START pulse; all sampling and driving happens at negedges.
    // coef_gap offers coefficients only on even cycles; abort_at stops once that many
    // coefficients were taken; poke_cyc re-pulses START with a bad size while busy.
    task automatic run_op(input int sx, input int su, input int sk, input bit coef_gap,
                          input int abort_at, input int poke_cyc);
        int xi = 0, ui = 0, ci = 0;
        bit xr = 0, ur = 0, cr = 0;
        n_out = 0; got_ready = 0; got_err = 0; aborted = 0; ready_cyc = -1;
        ever_x = 0; ever_u = 0; ever_c = 0;
        @(negedge CLK);
        START = 1'b1;
        SIZE_X_IN = DW'(sx); SIZE_U_IN = DW'(su); SIZE_K_IN = DW'(sk);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge CLK);
            START = 1'b0;
            if (X_IN_VALID && xr) xi++;
            if (U_IN_VALID && ur) ui++;
            if (COEF_IN_VALID && cr) ci++;
            if (X_OUT_ENABLE && n_out < 16) begin
                o_val[n_out] = X_OUT; o_i[n_out] = int'(X_OUT_I);
                o_k[n_out] = int'(X_OUT_K); o_cyc[n_out] = cyc;
                n_out++;
            end
            if (READY) begin
                got_ready = 1; got_err = ERROR; ready_cyc = cyc;
                break;
            end
            if (abort_at >= 0 && ci == abort_at) begin
                aborted = 1;
                break;
            end
            if (cyc == poke_cyc) begin
                START = 1'b1; SIZE_X_IN = '0;
            end
            xr = X_IN_READY; ur = U_IN_READY; cr = COEF_IN_READY;
            ever_x |= xr; ever_u |= ur; ever_c |= cr;
            X_IN_VALID    = xr && (xi < nx);
            X_IN          = x_data[xi & 15];
            U_IN_VALID    = ur && (ui < nu);
            U_IN          = u_data[ui & 15];
            COEF_IN_VALID = cr && (ci < nc) && (!coef_gap || (cyc % 2 == 0));
            COEF_IN       = c_data[ci & 15];
        end
        X_IN_VALID = 1'b0; U_IN_VALID = 1'b0; COEF_IN_VALID = 1'b0;
        coefs_taken = ci;
        if (!got_ready && !aborted) begin
            checks++; errors++;
            $display("FAIL timeout: no READY within 400 cycles (sx=%0d su=%0d sk=%0d)", sx, su, sk);
        end
    endtask

    task automatic load_first();
        x_data[0] = 16'h0100; x_data[1] = 16'h0200; nx = 2;
        u_data[0] = 16'h0100; nu = 1;
        c_data[0] = 16'h0100; c_data[1] = 16'h0000; c_data[2] = 16'h0080;
        c_data[3] = 16'h0000; c_data[4] = 16'h0100; c_data[5] = 16'h0040; nc = 6;
    endtask

    // Shared result checks for the two-row, one-input, one-step scenario.
    task automatic check_first(input string tag);
        logic [DW-1:0] exp_val [2];
        exp_val[0] = 16'h0180; exp_val[1] = 16'h0240;
        checks++;
        if (got_ready !== 1'b1 || got_err !== 1'b0) begin
            errors++; $display("FAIL %s_done: ready=%0d error=%0d required 1/0", tag, got_ready, got_err);
        end
        checks++;
        if (n_out !== 2) begin
            errors++; $display("FAIL %s_count: got %0d outputs required 2", tag, n_out);
        end
        for (int r = 0; r < 2; r++) begin
            checks++;
            if (o_val[r] !== exp_val[r] || o_i[r] !== r || o_k[r] !== 0) begin
                errors++;
                $display("FAIL %s_row%0d: x=%h i=%0d k=%0d required x=%h i=%0d k=0",
                         tag, r, o_val[r], o_i[r], o_k[r], exp_val[r], r);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({READY, BUSY, ERROR, X_IN_READY, U_IN_READY, COEF_IN_READY, X_OUT_ENABLE,
             X_OUT, X_OUT_I, X_OUT_K} !== '0) begin
            errors++; $display("FAIL reset_outputs: some output nonzero during reset, required all 0");
        end
        @(negedge CLK); RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({BUSY, READY, X_IN_READY, U_IN_READY, COEF_IN_READY} !== 5'b0) begin
            errors++; $display("FAIL reset_idle: busy/ready=%b required 00000",
                               {BUSY, READY, X_IN_READY, U_IN_READY, COEF_IN_READY});
        end
    endtask

    task automatic test_basic();
        load_first();
        run_op(2, 1, 1, 1'b0, -1, -1);
        check_first("basic");
        checks++;
        if (o_cyc[1] - o_cyc[0] !== 4) begin
            errors++; $display("FAIL basic_row_spacing: %0d cycles required 4", o_cyc[1] - o_cyc[0]);
        end
        checks++;
        if (ready_cyc - o_cyc[1] !== 2) begin
            errors++; $display("FAIL basic_ready_latency: %0d cycles required 2", ready_cyc - o_cyc[1]);
        end
        checks++;
        if (BUSY !== 1'b1) begin
            errors++; $display("FAIL basic_busy_at_ready: busy=%0d required 1", BUSY);
        end
    endtask

    task automatic test_no_input();
        logic [DW-1:0] exp_val [3];
        exp_val[0] = 16'h0200; exp_val[1] = 16'h0400; exp_val[2] = 16'h0800;
        x_data[0] = 16'h0100; nx = 1; nu = 0;
        c_data[0] = 16'h0200; c_data[1] = 16'h0200; c_data[2] = 16'h0200; nc = 3;
        run_op(1, 0, 3, 1'b0, -1, -1);
        checks++;
        if (got_ready !== 1'b1 || got_err !== 1'b0 || n_out !== 3) begin
            errors++; $display("FAIL no_input_done: ready=%0d error=%0d outputs=%0d required 1/0/3",
                               got_ready, got_err, n_out);
        end
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (o_val[s] !== exp_val[s] || o_k[s] !== s || o_i[s] !== 0) begin
                errors++; $display("FAIL no_input_step%0d: x=%h i=%0d k=%0d required x=%h i=0 k=%0d",
                                   s, o_val[s], o_i[s], o_k[s], exp_val[s], s);
            end
        end
        checks++;
        if (ever_u !== 1'b0) begin
            errors++; $display("FAIL no_input_u_ready: U_IN_READY seen high, required never");
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_val;
`ifdef STANDARD_LINEAR_SATURATION_EN
        exp_val = 16'h7FFF;
`else
        exp_val = 16'hE000;
`endif
        x_data[0] = 16'h7000; nx = 1; nu = 0;
        c_data[0] = 16'h0200; nc = 1;
        run_op(1, 0, 1, 1'b0, -1, -1);
        checks++;
        if (n_out !== 1 || o_val[0] !== exp_val) begin
            errors++; $display("FAIL overflow: outputs=%0d x=%h required 1 output x=%h", n_out, o_val[0], exp_val);
        end
    endtask

    task automatic test_coef_gaps();
        load_first();
        run_op(2, 1, 1, 1'b1, -1, 3);
        check_first("gaps");
        checks++;
        if (coefs_taken !== 6) begin
            errors++; $display("FAIL gaps_coef_count: %0d coefficients taken required 6", coefs_taken);
        end
    endtask

    task automatic test_size_error();
        int sx_t [4] = '{0, XM + 1, 1, 1};
        int su_t [4] = '{1, 1, UM + 1, 0};
        int sk_t [4] = '{1, 1, 1, 0};
        nx = 2; nu = 1; nc = 6;
        for (int t = 0; t < 4; t++) begin
            run_op(sx_t[t], su_t[t], sk_t[t], 1'b0, -1, -1);
            checks++;
            if (got_ready !== 1'b1 || got_err !== 1'b1 || ready_cyc !== 2) begin
                errors++; $display("FAIL size_error%0d: ready=%0d error=%0d at cycle %0d required 1/1 at 2",
                                   t, got_ready, got_err, ready_cyc);
            end
            checks++;
            if ({ever_x, ever_u, ever_c} !== 3'b000) begin
                errors++; $display("FAIL size_error%0d_streams: ready seen %b required 000",
                                   t, {ever_x, ever_u, ever_c});
            end
        end
    endtask

    task automatic test_reset_mid_op();
        load_first();
        run_op(2, 1, 1, 1'b0, 4, -1);
        checks++;
        if (aborted !== 1'b1 || COEF_IN_READY !== 1'b1) begin
            errors++; $display("FAIL midreset_reach: aborted=%0d coef_ready=%0d required 1/1",
                               aborted, COEF_IN_READY);
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({READY, BUSY, ERROR, X_IN_READY, U_IN_READY, COEF_IN_READY, X_OUT_ENABLE,
             X_OUT, X_OUT_I, X_OUT_K} !== '0) begin
            errors++; $display("FAIL midreset_outputs: some output nonzero after reset, required all 0");
        end
        @(negedge CLK); RST = 1'b1;
        run_op(2, 1, 1, 1'b0, -1, -1);
        check_first("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_input();
        test_overflow();
        test_coef_gaps();
        test_size_error();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
